// File: rtl/br_multi_xfer_mux_rr_if.sv
// Multi-transfer push/pop bundle for br_multi_xfer_mux_rr: NumPorts push sides sharing one pop side.
interface br_multi_xfer_mux_rr_if #(
  parameter int NumPorts    = 2,
  parameter int NumSymbols  = 2,
  parameter int SymbolWidth = 1
);
  localparam int CountWidth = $clog2(NumSymbols + 1);

  logic [NumPorts-1:0][CountWidth-1:0]                   push_sendable;
  logic [NumPorts-1:0][CountWidth-1:0]                   push_receivable;
  logic [NumPorts-1:0][NumSymbols-1:0][SymbolWidth-1:0]  push_data;
  logic [CountWidth-1:0]                                 pop_sendable;
  logic [CountWidth-1:0]                                 pop_receivable;
  logic [NumSymbols-1:0][SymbolWidth-1:0]                pop_data;

  modport master (
    output push_sendable, push_data, pop_receivable,
    input  push_receivable, pop_sendable, pop_data
  );

  modport slave (
    input  push_sendable, push_data, pop_receivable,
    output push_receivable, pop_sendable, pop_data
  );
endinterface

// File: rtl/br_multi_xfer_mux_rr.sv
// Round-robin mux of NumPorts multi-transfer push streams onto one pop stream, holding the grant until drained.
// Optional per-port saturating accepted-symbol counters: define BR_MULTI_XFER_MUX_RR_XFER_COUNT_EN.
module br_multi_xfer_mux_rr #(
  parameter int NumPorts     = 2,
  parameter int NumSymbols   = 2,
  parameter int SymbolWidth  = 1,
  parameter int CounterWidth = 16
) (
  input  logic clk,
  input  logic rst,
`ifdef BR_MULTI_XFER_MUX_RR_XFER_COUNT_EN
  output logic [NumPorts-1:0][CounterWidth-1:0] xfer_count,
`endif
  br_multi_xfer_mux_rr_if.slave bus
);
  localparam int CountWidth = $clog2(NumSymbols + 1);
  localparam int PtrWidth   = $clog2(NumPorts);

  logic                  locked_reg, locked_next;
  logic [PtrWidth-1:0]   lock_idx_reg, lock_idx_next;
  logic [PtrWidth-1:0]   prio_ptr_reg, prio_ptr_next;
  logic [CountWidth-1:0] remaining_reg, remaining_next;

  logic                  grant;
  logic [PtrWidth-1:0]   sel;
  logic [CountWidth-1:0] sel_sendable;
  logic [CountWidth-1:0] accepted;
  logic                  full_drain;
  int                    cand;

  // While locked the search result is ignored, so unselected requesters never reach the outputs.
  always_comb begin
    grant = 1'b0;
    sel   = '0;
    cand  = 0;
    if (locked_reg) begin
      grant = 1'b1;
      sel   = lock_idx_reg;
    end else begin
      for (int i = 0; i < NumPorts; i++) begin
        cand = int'(prio_ptr_reg) + i;
        if (cand >= NumPorts) cand = cand - NumPorts;
        if (!grant && bus.push_sendable[cand] != '0) begin
          grant = 1'b1;
          sel   = PtrWidth'(cand);
        end
      end
    end
  end

  always_comb begin
    sel_sendable = '0;
    bus.pop_data = '0;
    if (grant) begin
      sel_sendable = bus.push_sendable[sel];
      bus.pop_data = bus.push_data[sel];
    end
  end

  assign bus.pop_sendable = sel_sendable;
  assign full_drain       = (bus.pop_receivable >= sel_sendable);
  assign accepted         = full_drain ? sel_sendable : bus.pop_receivable;

  generate
    for (genvar gi = 0; gi < NumPorts; gi++) begin : g_rcv
      assign bus.push_receivable[gi] =
        (grant && sel == PtrWidth'(gi)) ? bus.pop_receivable : '0;
    end
  endgenerate

  always_comb begin
    locked_next    = locked_reg;
    lock_idx_next  = lock_idx_reg;
    prio_ptr_next  = prio_ptr_reg;
    remaining_next = remaining_reg;
    if (grant) begin
      if (full_drain) begin
        locked_next   = 1'b0;
        prio_ptr_next = (sel == PtrWidth'(NumPorts - 1)) ? '0 : PtrWidth'(sel + 1'b1);
      end else begin
        locked_next    = 1'b1;
        lock_idx_next  = sel;
        remaining_next = sel_sendable - accepted;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      locked_reg    <= 1'b0;
      lock_idx_reg  <= '0;
      prio_ptr_reg  <= '0;
      remaining_reg <= '0;
    end else begin
      locked_reg    <= locked_next;
      lock_idx_reg  <= lock_idx_next;
      prio_ptr_reg  <= prio_ptr_next;
      remaining_reg <= remaining_next;
    end
  end

`ifdef BR_MULTI_XFER_MUX_RR_XFER_COUNT_EN
  generate
    for (genvar gi = 0; gi < NumPorts; gi++) begin : g_cnt
      logic [CounterWidth-1:0] count_reg;
      logic [CounterWidth:0]   sum;
      assign sum = {1'b0, count_reg} +
                   ((grant && sel == PtrWidth'(gi)) ? (CounterWidth + 1)'(accepted) : '0);
      always_ff @(posedge clk) begin
        if (rst) count_reg <= '0;
        else     count_reg <= sum[CounterWidth] ? {CounterWidth{1'b1}} : sum[CounterWidth-1:0];
      end
      assign xfer_count[gi] = count_reg;
    end
  endgenerate
`endif

  // Senders may only shift leftovers down, never withdraw them, while holding the lock.
  a_locked_nonzero: assert property (@(posedge clk) disable iff (rst)
    locked_reg |-> bus.push_sendable[lock_idx_reg] != '0);
  a_locked_stable: assert property (@(posedge clk) disable iff (rst)
    locked_reg |-> bus.push_sendable[lock_idx_reg] >= remaining_reg);
endmodule
